// File: rtl/dds_phase2amp_if.sv
// Sample-path bundle between the phase accumulator and the phase-to-amplitude stage.
// The master side drives phase and waveform selection; the slave side returns DAC samples.
interface dds_phase2amp_if #(
    parameter int ACC_W = 32,
    parameter int PW    = 11,
    parameter int DW    = 10
);
    logic [ACC_W-1:0] phase_in;
    logic [PW-1:0]    phase_off;
    logic             in_valid;
    logic [1:0]       wave_sel;
    logic             sel_load;
    logic [DW-1:0]    amp_out;
    logic             out_valid;
    logic [1:0]       sel_active;

    modport master (
        output phase_in, phase_off, in_valid, wave_sel, sel_load,
        input  amp_out, out_valid, sel_active
    );

    modport slave (
        input  phase_in, phase_off, in_valid, wave_sel, sel_load,
        output amp_out, out_valid, sel_active
    );
endinterface

// File: rtl/dds_phase2amp.sv
// Phase-to-amplitude stage: offset the truncated accumulator phase, then map it to a sine,
// triangle, sawtooth or square DAC sample over three pipeline stages.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_ACTIVE  | no selection waiting; samples use sel_active
//  S_PENDING | a new selection waits for the next wrap sample to take over
module dds_phase2amp #(
    parameter int ACC_W = 32,
    parameter int PW    = 11,
    parameter int DW    = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    dds_phase2amp_if.slave bus
);
    localparam int QN = 2 ** (PW - 2);
    localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};
    localparam logic [1:0] WAVE_SINE = 2'd0;
    localparam logic [1:0] WAVE_TRI  = 2'd1;
    localparam logic [1:0] WAVE_SAW  = 2'd2;
    localparam logic [1:0] WAVE_SQR  = 2'd3;

    typedef enum logic {S_ACTIVE, S_PENDING} sel_state_t;

    // Quarter-wave table sampled at half-LSB offsets so the mirrored read is exactly symmetric.
    function automatic logic [DW-2:0] q_entry(int i);
        real x;
        x = real'(2 ** (DW - 1) - 1)
            * $sin(2.0 * 3.14159265358979323846 * (real'(i) + 0.5) / real'(2 ** PW));
        return (DW-1)'($rtoi(x + 0.5));
    endfunction

    logic [DW-2:0] rom [QN];

    for (genvar gi = 0; gi < QN; gi++) begin : g_rom
        localparam logic [DW-2:0] QV = q_entry(gi);
        assign rom[gi] = QV;
    end

    sel_state_t    state_q, state_d;
    logic [1:0]    pend_q, pend_d;
    logic [1:0]    act_q, act_d;
    logic [PW-1:0] last_p_q, last_p_d;
    logic          first_q, first_d;
    logic          wrap;

    logic          v1_q;
    logic [PW-1:0] p1_q, p1_d;
    logic [1:0]    sel1_q, sel1_d;

    logic          v2_q;
    logic          sine2_q;
    logic          neg2_q;
    logic [DW-2:0] rom2_q;
    logic [DW-1:0] alt2_q, alt2_d;
    logic [PW-3:0] idx2_d;
    logic [DW-1:0] tri_t;

    logic          ov_q;
    logic [DW-1:0] amp_q, amp_d;

    logic unused_lsbs;
    assign unused_lsbs = ^bus.phase_in[ACC_W-PW-1:0];

    assign p1_d = bus.phase_in[ACC_W-1 -: PW] + bus.phase_off;
    assign wrap = bus.in_valid && (first_q || (p1_d < last_p_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_ACTIVE;
            pend_q   <= '0;
            act_q    <= '0;
            last_p_q <= '0;
            first_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            act_q    <= act_d;
            last_p_q <= last_p_d;
            first_q  <= first_d;
        end
    end

    // A same-cycle sel_load is visible to the wrap decision through pend_d.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        act_d    = act_q;
        last_p_d = last_p_q;
        first_d  = first_q;
        sel1_d   = act_q;
        if (bus.sel_load) begin
            pend_d  = bus.wave_sel;
            state_d = S_PENDING;
        end
        if (wrap && (bus.sel_load || state_q == S_PENDING)) begin
            act_d   = pend_d;
            sel1_d  = pend_d;
            state_d = S_ACTIVE;
        end
        if (bus.in_valid) begin
            last_p_d = p1_d;
            first_d  = 1'b0;
        end
    end

    always_comb begin
        idx2_d = p1_q[PW-2] ? ~p1_q[PW-3:0] : p1_q[PW-3:0];
        tri_t  = p1_q[PW-2 -: DW];
        alt2_d = '0;
        case (sel1_q)
            WAVE_TRI:  alt2_d = p1_q[PW-1] ? ~tri_t : tri_t;
            WAVE_SAW:  alt2_d = p1_q[PW-1 -: DW];
            WAVE_SQR:  alt2_d = p1_q[PW-1] ? '0 : '1;
            default:   alt2_d = '0;
        endcase
    end

    always_comb begin
        amp_d = alt2_q;
        if (sine2_q) begin
            amp_d = neg2_q ? (MID - {1'b0, rom2_q}) : (MID + {1'b0, rom2_q});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            p1_q    <= '0;
            sel1_q  <= '0;
            v2_q    <= 1'b0;
            sine2_q <= 1'b0;
            neg2_q  <= 1'b0;
            rom2_q  <= '0;
            alt2_q  <= '0;
            ov_q    <= 1'b0;
            amp_q   <= MID;
        end else begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                p1_q   <= p1_d;
                sel1_q <= sel1_d;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                sine2_q <= (sel1_q == WAVE_SINE);
                neg2_q  <= p1_q[PW-1];
                rom2_q  <= rom[idx2_d];
                alt2_q  <= alt2_d;
            end
            ov_q <= v2_q;
            if (v2_q) begin
                amp_q <= amp_d;
            end
        end
    end

    assign bus.amp_out    = amp_q;
    assign bus.out_valid  = ov_q;
    assign bus.sel_active = act_q;
endmodule
